// File: rtl/get_cube_pkg.sv
// rtl/get_cube_pkg.sv - shared constants, edge groups and edge-to-vertex mapping for get_cube
// Vertex indices: 0..3 are front corners F0..F3, 4..7 are back corners B0..B3.
package get_cube_pkg;

  localparam int N_LINES = 12;
  localparam int N_VERTS = 8;

  localparam logic [7:0] COL_FRONT = 8'hFF;
  localparam logic [7:0] COL_BACK  = 8'd1;
  localparam logic [7:0] COL_CONN  = 8'd2;
  localparam logic [7:0] COL_BLANK = 8'd0;

  typedef enum logic [1:0] {
    FRONT,
    BACK,
    CONN
  } edge_group_t;

  typedef struct packed {
    logic [2:0] v_start;
    logic [2:0] v_end;
  } vert_pair_t;

  function automatic edge_group_t edge_group(input logic [31:0] idx);
    if (idx < 32'd4)
      return FRONT;
    else if (idx < 32'd8)
      return BACK;
    else
      return CONN;
  endfunction

  // Face edges walk the ring k -> k+1 (mod 4); connectors join Fk to Bk.
  function automatic vert_pair_t edge_verts(input logic [31:0] idx);
    vert_pair_t p;
    logic [1:0] k;
    logic [1:0] k_next;
    k      = idx[1:0];
    k_next = k + 2'd1;
    if (idx < 32'd4) begin
      p.v_start = {1'b0, k};
      p.v_end   = {1'b0, k_next};
    end else if (idx < 32'd8) begin
      p.v_start = {1'b1, k};
      p.v_end   = {1'b1, k_next};
    end else begin
      p.v_start = {1'b0, k};
      p.v_end   = {1'b1, k};
    end
    return p;
  endfunction

endpackage

// File: rtl/cube_vertex_rom.sv
// rtl/cube_vertex_rom.sv - combinational vertex index to screen (x,y) lookup
// All coordinates are elaboration constants; back face is the front face shifted by (OX, -OY).
module cube_vertex_rom
  import get_cube_pkg::*;
#(
  parameter int XY_BITW = 16,
  parameter int W       = 10,
  parameter int H       = 10,
  parameter int OX      = 5,
  parameter int OY      = 5
) (
  input  logic [2:0]         vid,
  output logic [XY_BITW-1:0] x,
  output logic [XY_BITW-1:0] y
);

  localparam logic [XY_BITW-1:0] X_FL = '0;
  localparam logic [XY_BITW-1:0] X_FR = XY_BITW'(W);
  localparam logic [XY_BITW-1:0] X_BL = XY_BITW'(OX);
  localparam logic [XY_BITW-1:0] X_BR = XY_BITW'(W + OX);
  localparam logic [XY_BITW-1:0] Y_FT = XY_BITW'(OY);
  localparam logic [XY_BITW-1:0] Y_FB = XY_BITW'(OY + H);
  localparam logic [XY_BITW-1:0] Y_BT = '0;
  localparam logic [XY_BITW-1:0] Y_BB = XY_BITW'(H);

  always_comb begin
    x = '0;
    y = '0;
    case (vid)
      3'd0: begin x = X_FL; y = Y_FT; end
      3'd1: begin x = X_FR; y = Y_FT; end
      3'd2: begin x = X_FR; y = Y_FB; end
      3'd3: begin x = X_FL; y = Y_FB; end
      3'd4: begin x = X_BL; y = Y_BT; end
      3'd5: begin x = X_BR; y = Y_BT; end
      3'd6: begin x = X_BR; y = Y_BB; end
      3'd7: begin x = X_BL; y = Y_BB; end
      default: begin x = '0; y = '0; end
    endcase
  end

endmodule

// File: rtl/get_cube.sv
// rtl/get_cube.sv - registered edge lookup for an oblique-projected wireframe cuboid
// Optional GET_CUBE_HIDDEN_EN blanks the colour of the three edges touching hidden vertex B3.
module get_cube
  import get_cube_pkg::*;
#(
  parameter int XY_BITW = 16,
  parameter int LINEW   = 4,
  parameter int COLORW  = 3,
  parameter int WIDTH   = 10,
  parameter int HEIGHT  = 10,
  parameter int DEPTH   = 5,
  parameter int ADJ_DEG = 45,
  parameter int SCALE   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINEW-1:0]   line_id,
  output logic [COLORW-1:0]  color,
  output logic [XY_BITW-1:0] x0,
  output logic [XY_BITW-1:0] y0,
  output logic [XY_BITW-1:0] x1,
  output logic [XY_BITW-1:0] y1
);

  localparam int W  = WIDTH * SCALE;
  localparam int H  = HEIGHT * SCALE;
  localparam int D  = DEPTH * SCALE;
  localparam int OX = (ADJ_DEG == 90) ? 0 : D;
  localparam int OY = (ADJ_DEG == 0)  ? 0 : D;

  localparam logic [COLORW-1:0] C_FRONT = '1;
  localparam logic [COLORW-1:0] C_BACK  = COLORW'(COL_BACK);
  localparam logic [COLORW-1:0] C_CONN  = COLORW'(COL_CONN);
  localparam logic [COLORW-1:0] C_BLANK = COLORW'(COL_BLANK);

  generate
    if (ADJ_DEG != 0 && ADJ_DEG != 45 && ADJ_DEG != 90) begin : g_bad_angle
      $error("get_cube: ADJ_DEG must be 0, 45 or 90");
    end
    if (((W + OX) >> XY_BITW) != 0 || ((OY + H) >> XY_BITW) != 0) begin : g_bad_width
      $error("get_cube: cuboid extent does not fit in XY_BITW bits");
    end
  endgenerate

  logic [31:0]        idx;
  logic               in_range;
  vert_pair_t         pair;
  edge_group_t        group;
  logic [XY_BITW-1:0] xs, ys, xe, ye;
  logic [COLORW-1:0]  color_d;
  logic [XY_BITW-1:0] x0_d, y0_d, x1_d, y1_d;

  assign idx      = 32'(line_id);
  assign in_range = (idx < 32'(N_LINES));
  assign pair     = edge_verts(idx);
  assign group    = edge_group(idx);

  cube_vertex_rom #(
    .XY_BITW(XY_BITW), .W(W), .H(H), .OX(OX), .OY(OY)
  ) u_rom_start (
    .vid(pair.v_start),
    .x  (xs),
    .y  (ys)
  );

  cube_vertex_rom #(
    .XY_BITW(XY_BITW), .W(W), .H(H), .OX(OX), .OY(OY)
  ) u_rom_end (
    .vid(pair.v_end),
    .x  (xe),
    .y  (ye)
  );

  always_comb begin
    color_d = C_BLANK;
    x0_d    = '0;
    y0_d    = '0;
    x1_d    = '0;
    y1_d    = '0;
    if (in_range) begin
      x0_d = xs;
      y0_d = ys;
      x1_d = xe;
      y1_d = ye;
      case (group)
        FRONT:   color_d = C_FRONT;
        BACK:    color_d = C_BACK;
        CONN:    color_d = C_CONN;
        default: color_d = C_BLANK;
      endcase
`ifdef GET_CUBE_HIDDEN_EN
      // B3 is the corner occluded by the front face; its edges keep geometry but draw blank.
      if (pair.v_start == 3'd7 || pair.v_end == 3'd7)
        color_d = C_BLANK;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      color <= '0;
      x0    <= '0;
      y0    <= '0;
      x1    <= '0;
      y1    <= '0;
    end else begin
      color <= color_d;
      x0    <= x0_d;
      y0    <= y0_d;
      x1    <= x1_d;
      y1    <= y1_d;
    end
  end

endmodule

// File: tb/tb_get_cube.sv
// tb/tb_get_cube.sv - table-driven check of get_cube at ADJ_DEG 45 and 0
module tb_get_cube;

  typedef struct {
    logic [3:0]  lid;
    logic [15:0] x0;
    logic [15:0] y0;
    logic [15:0] x1;
    logic [15:0] y1;
    logic [2:0]  col;
  } vec_t;

`ifdef GET_CUBE_HIDDEN_EN
  localparam logic [2:0] C_HB = 3'd0;
  localparam logic [2:0] C_HC = 3'd0;
`else
  localparam logic [2:0] C_HB = 3'd1;
  localparam logic [2:0] C_HC = 3'd2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  line_id;
  logic [2:0]  a_col, z_col;
  logic [15:0] a_x0, a_y0, a_x1, a_y1;
  logic [15:0] z_x0, z_y0, z_x1, z_y1;

  int checks   = 0;
  int failures = 0;

  vec_t v45[14];
  vec_t v0[14];

  always #5 clk = ~clk;

  get_cube #(.ADJ_DEG(45)) dut (
    .clk(clk), .rst(rst), .line_id(line_id), .color(a_col),
    .x0(a_x0), .y0(a_y0), .x1(a_x1), .y1(a_y1)
  );

  get_cube #(.ADJ_DEG(0)) dut0 (
    .clk(clk), .rst(rst), .line_id(line_id), .color(z_col),
    .x0(z_x0), .y0(z_y0), .x1(z_x1), .y1(z_y1)
  );

  function automatic vec_t mk(input int lid, input int x0, input int y0,
                              input int x1, input int y1, input logic [2:0] col);
    vec_t v;
    v.lid = 4'(lid);
    v.x0 = 16'(x0);
    v.y0 = 16'(y0);
    v.x1 = 16'(x1);
    v.y1 = 16'(y1);
    v.col = col;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk45(input string tag, input vec_t e);
    chk({tag, " a45.x0"}, a_x0, e.x0);
    chk({tag, " a45.y0"}, a_y0, e.y0);
    chk({tag, " a45.x1"}, a_x1, e.x1);
    chk({tag, " a45.y1"}, a_y1, e.y1);
    chk({tag, " a45.col"}, 16'(a_col), 16'(e.col));
  endtask

  task automatic chk0(input string tag, input vec_t e);
    chk({tag, " a0.x0"}, z_x0, e.x0);
    chk({tag, " a0.y0"}, z_y0, e.y0);
    chk({tag, " a0.x1"}, z_x1, e.x1);
    chk({tag, " a0.y1"}, z_y1, e.y1);
    chk({tag, " a0.col"}, 16'(z_col), 16'(e.col));
  endtask

  initial begin
    vec_t zero;
    zero = mk(0, 0, 0, 0, 0, 3'd0);

    // ADJ_DEG=45: F0(0,5) F1(10,5) F2(10,15) F3(0,15) B0(5,0) B1(15,0) B2(15,10) B3(5,10)
    v45[0]  = mk(0,  0, 5, 10, 5, 3'd7);
    v45[1]  = mk(1, 10, 5, 10, 15, 3'd7);
    v45[2]  = mk(2, 10, 15, 0, 15, 3'd7);
    v45[3]  = mk(3,  0, 15, 0, 5, 3'd7);
    v45[4]  = mk(4,  5, 0, 15, 0, 3'd1);
    v45[5]  = mk(5, 15, 0, 15, 10, 3'd1);
    v45[6]  = mk(6, 15, 10, 5, 10, C_HB);
    v45[7]  = mk(7,  5, 10, 5, 0, C_HB);
    v45[8]  = mk(8,  0, 5, 5, 0, 3'd2);
    v45[9]  = mk(9, 10, 5, 15, 0, 3'd2);
    v45[10] = mk(10, 10, 15, 15, 10, 3'd2);
    v45[11] = mk(11, 0, 15, 5, 10, C_HC);
    v45[12] = mk(12, 0, 0, 0, 0, 3'd0);
    v45[13] = mk(15, 0, 0, 0, 0, 3'd0);

    // ADJ_DEG=0: F0(0,0) F1(10,0) F2(10,10) F3(0,10), back face unchanged
    v0[0]  = mk(0,  0, 0, 10, 0, 3'd7);
    v0[1]  = mk(1, 10, 0, 10, 10, 3'd7);
    v0[2]  = mk(2, 10, 10, 0, 10, 3'd7);
    v0[3]  = mk(3,  0, 10, 0, 0, 3'd7);
    v0[4]  = mk(4,  5, 0, 15, 0, 3'd1);
    v0[5]  = mk(5, 15, 0, 15, 10, 3'd1);
    v0[6]  = mk(6, 15, 10, 5, 10, C_HB);
    v0[7]  = mk(7,  5, 10, 5, 0, C_HB);
    v0[8]  = mk(8,  0, 0, 5, 0, 3'd2);
    v0[9]  = mk(9, 10, 0, 15, 0, 3'd2);
    v0[10] = mk(10, 10, 10, 15, 10, 3'd2);
    v0[11] = mk(11, 0, 10, 5, 10, C_HC);
    v0[12] = mk(12, 0, 0, 0, 0, 3'd0);
    v0[13] = mk(15, 0, 0, 0, 0, 3'd0);

    // Reset with a valid line_id applied must still clear everything.
    rst = 1'b1;
    line_id = 4'd2;
    @(posedge clk); #1;
    chk45("reset", zero);
    chk0("reset", zero);
    line_id = 4'd0;
    @(posedge clk); #1;
    chk45("reset_hold", zero);

    // Forward sweep on consecutive cycles, including out-of-range ids.
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      line_id = v45[i].lid;
      @(posedge clk); #1;
      chk45($sformatf("fwd[%0d]", v45[i].lid), v45[i]);
      chk0($sformatf("fwd[%0d]", v0[i].lid), v0[i]);
    end

    // Reverse sweep catches stale or skipped registers in the other direction.
    for (int i = 11; i >= 0; i--) begin
      line_id = v45[i].lid;
      @(posedge clk); #1;
      chk45($sformatf("rev[%0d]", v45[i].lid), v45[i]);
      chk0($sformatf("rev[%0d]", v0[i].lid), v0[i]);
    end

    // Output must hold between edges even when line_id changes mid-cycle.
    line_id = 4'd0;
    @(posedge clk); #1;
    line_id = 4'd10;
    #3;
    chk45("hold", v45[0]);
    @(posedge clk); #1;
    chk45("after_hold", v45[10]);

    // Mid-stream reset, then recovery on the next edge.
    line_id = 4'd1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk45("mid_reset", zero);
    chk0("mid_reset", zero);
    rst = 1'b0;
    line_id = 4'd8;
    @(posedge clk); #1;
    chk45("recover", v45[8]);
    chk0("recover", v0[8]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
